// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one ready/valid sink between N_REQ ready/valid sources.
// A grant lasts up to MAX_BURST beats and ends early when the holder drops valid.
module rr_stream_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 8,
    localparam int SRC_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_mask,
    input  logic [N_REQ-1:0]       in_valid,
    input  logic [N_REQ*WIDTH-1:0] in_data,
    output logic [N_REQ-1:0]       in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [SRC_W-1:0]       out_src,
    output logic                   busy
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(MAX_BURST - 1);

    logic [0:0]                  state;
    logic [SRC_W-1:0]            gnt, last, pick, pick_hi, pick_lo;
    logic                        found_hi;
    logic [CNT_W-1:0]            beat_cnt;
    logic [N_REQ-1:0]            eligible;
    logic [N_REQ-1:0][WIDTH-1:0] data_arr;
    logic                        granted;

    assign data_arr = in_data;
    assign eligible = in_valid & req_mask;
    assign granted  = (state == S_GRANT);

    // Descending scan leaves the lowest eligible index above 'last' in pick_hi and the
    // lowest eligible index overall in pick_lo; the latter covers the wrap-around case.
    always_comb begin
        pick_hi  = last;
        pick_lo  = last;
        found_hi = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                if (SRC_W'(i) > last) begin
                    pick_hi  = SRC_W'(i);
                    found_hi = 1'b1;
                end
                pick_lo = SRC_W'(i);
            end
        end
        pick = found_hi ? pick_hi : pick_lo;
    end

    generate
        for (genvar g = 0; g < N_REQ; g++) begin : g_rdy
            assign in_ready[g] = granted && (gnt == SRC_W'(g)) && out_ready;
        end
    endgenerate

    assign out_valid = granted && in_valid[gnt];
    assign out_data  = granted ? data_arr[gnt] : '0;
    assign out_src   = granted ? gnt : last;
    assign busy      = granted;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            gnt      <= '0;
            last     <= SRC_W'(N_REQ - 1);
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|eligible) begin
                        gnt      <= pick;
                        beat_cnt <= '0;
                        state    <= S_GRANT;
                    end
                end
                default: begin
                    if (!in_valid[gnt]) begin
                        state <= S_IDLE;
                        last  <= gnt;
                    end else if (out_ready) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == BEAT_LAST) begin
                            state <= S_IDLE;
                            last  <= gnt;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Directed bench for rr_stream_arbiter: sources emit {index, sequence} so every
// transferred beat identifies its producer and order.
module tb_rr_stream_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_mask, in_valid, in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid, out_ready, busy;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic [3:0]     seq [N];
    int             exp_seq [N];
    int             n_cmp = 0;
    int             n_err = 0;

    always #5 clk = ~clk;

    rr_stream_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req_mask(req_mask), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .out_src(out_src), .busy(busy)
    );

    // Source model: advance a per-source sequence number on each accepted beat.
    always @(posedge clk)
        for (int i = 0; i < N; i++)
            if (!rst_n) seq[i] <= '0;
            else if (in_valid[i] && in_ready[i]) seq[i] <= seq[i] + 1'b1;

    always_comb begin
        in_data = '0;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = {4'(i), seq[i]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int s);
        logic [3:0] sn;
        sn = 4'(exp_seq[s]);
        chk("beat_busy", 32'(busy), 1);
        chk("beat_src", 32'(out_src), s);
        chk("beat_ready", 32'(in_ready), 1 << s);
        chk("beat_valid", 32'(out_valid), 1);
        chk("beat_data", 32'(out_data), {s[3:0], sn});
        exp_seq[s]++;
        step();
    endtask

    task automatic idle(input int s);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_src", 32'(out_src), s);
        chk("idle_ready", 32'(in_ready), 0);
        chk("idle_valid", 32'(out_valid), 0);
        chk("idle_data", 32'(out_data), 0);
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) exp_seq[i] = 0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) exp_seq[i] = 0;
        req_mask  = 4'hF;
        in_valid  = 4'hF;
        out_ready = 1'b1;

        // Reset held with all sources valid
        rst_n = 1'b0;
        step();
        for (int c = 0; c < 3; c++) begin
            chk("rst_ready", 32'(in_ready), 0);
            chk("rst_valid", 32'(out_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            step();
        end
        rst_n = 1'b1;

        // Fairness: 0,1,2,3,0 with one idle bubble between bursts
        idle(3);
        for (int s = 0; s < N; s++) begin
            for (int b = 0; b < 4; b++) beat(s);
            idle(s);
        end
        for (int b = 0; b < 4; b++) beat(0);

        // Early release: source 2 drops valid after two beats
        in_valid = 4'b0100;
        do_reset();
        idle(3);
        beat(2);
        beat(2);
        in_valid = 4'b0000;
        #1;
        chk("drop_busy", 32'(busy), 1);
        chk("drop_valid", 32'(out_valid), 0);
        chk("drop_ready", 32'(in_ready), 4'b0100);
        step();
        idle(2);
        idle(2);
        chk("drop_xfers", 32'(seq[2]), 2);

        // Backpressure for 10 cycles after the first beat
        in_valid = 4'hF;
        do_reset();
        idle(3);
        beat(0);
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("bp_busy", 32'(busy), 1);
            chk("bp_src", 32'(out_src), 0);
            chk("bp_ready", 32'(in_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data", 32'(out_data), 8'h01);
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int b = 0; b < 3; b++) beat(0);
        idle(0);
        beat(1);

        // Masking: only 1 and 3 alternate; clearing the mask lets the burst finish
        req_mask = 4'b1010;
        do_reset();
        idle(3);
        for (int b = 0; b < 4; b++) beat(1);
        idle(1);
        for (int b = 0; b < 4; b++) beat(3);
        idle(3);
        beat(1);
        beat(1);
        req_mask = 4'b0000;
        #1;
        beat(1);
        beat(1);
        idle(1);
        idle(1);
        idle(1);

        // Reset mid-burst of requester 3
        req_mask = 4'hF;
        do_reset();
        idle(3);
        for (int s = 0; s < 3; s++) begin
            for (int b = 0; b < 4; b++) beat(s);
            idle(s);
        end
        beat(3);
        beat(3);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy_pre", 32'(busy), 1);
        step();
        for (int i = 0; i < N; i++) exp_seq[i] = 0;
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_ready", 32'(in_ready), 0);
        chk("mrst_src", 32'(out_src), 3);
        rst_n = 1'b1;
        idle(3);
        beat(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
